// File: rtl/uart_pkg.sv
// Shared definitions for the memory-mapped UART transmitter.
// Contents: register offsets (mem_addr[3:2]), serializer state encoding,
// STATUS register bit positions.
package uart_pkg;

    // Register offsets, decoded from mem_addr[3:2]
    localparam logic [1:0] ADDR_DATA = 2'd0;
    localparam logic [1:0] ADDR_STAT = 2'd1;
    localparam logic [1:0] ADDR_DIV  = 2'd2;

    // Serializer states; StParity is only reachable when UART_PARITY_EN is defined
    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StParity,
        StStop
    } tx_state_e;

    // STATUS register layout
    localparam int unsigned STAT_FULL  = 0;
    localparam int unsigned STAT_EMPTY = 1;
    localparam int unsigned STAT_BUSY  = 2;
    localparam int unsigned STAT_PAR   = 3;
    localparam int unsigned STAT_LEVEL = 8;  // [15:8]

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with registered pointers and combinational head read.
// Ports:
//   clk, rst      clock, synchronous active-high reset (flushes the FIFO)
//   push, wdata   write one entry (caller guarantees !full, or a pop in the same cycle)
//   pop, rdata    remove head entry; rdata always shows the current head
//   full, empty   occupancy flags
//   level         number of stored entries
module sync_fifo #(
    parameter int unsigned Width = 8,
    parameter int unsigned Depth = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [Width-1:0]         wdata,
    input  logic                     pop,
    output logic [Width-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(Depth):0]   level
);

    localparam int unsigned AW = $clog2(Depth);

    logic [Width-1:0] mem_q [Depth];
    // Pointers carry an extra wrap bit so full and empty are distinguishable
    logic [AW:0]      wptr_q, rptr_q;

    assign rdata = mem_q[rptr_q[AW-1:0]];
    assign empty = (wptr_q == rptr_q);
    assign full  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign level = wptr_q - rptr_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            if (push) wptr_q <= wptr_q + 1'b1;
            if (pop)  rptr_q <= rptr_q + 1'b1;
        end
    end

    // Storage needs no reset; a push into a full FIFO overwrites the slot being popped
    always_ff @(posedge clk) begin
        if (push) mem_q[wptr_q[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/uart_txm.sv
// UART transmitter slave on the picorv32 native memory bus.
// Firmware pushes bytes through DATA into a TX FIFO; a baud-timed serializer
// sends them as start, 8 data bits LSB first, [even parity], stop.
// Optional feature macro: UART_PARITY_EN (adds a parity bit, STATUS[3]=1).
// Ports:
//   clk, rst                    clock, synchronous active-high reset
//   mem_valid/addr/wdata/wstrb  bus request (already address-decoded)
//   mem_ready, mem_rdata        one-cycle completion pulse and read data
//   uart_tx                     serial line, idle high
//   irq_txe                     FIFO empty and serializer idle (registered)
module uart_txm
    import uart_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH  = 16,
    parameter logic [15:0] DEFAULT_DIV = 16'd433
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_valid,
    output logic        mem_ready,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    input  logic [3:0]  mem_wstrb,
    output logic [31:0] mem_rdata,
    output logic        uart_tx,
    output logic        irq_txe
);

    localparam int unsigned LW = $clog2(FIFO_DEPTH) + 1;

    logic [1:0]    reg_addr;
    logic          is_write, req, data_push_req, stall, accept;
    logic          fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [7:0]    fifo_rdata;
    logic [LW-1:0] fifo_level;
    logic [31:0]   status;

    logic          mem_ready_q, mem_ready_d;
    logic [31:0]   mem_rdata_q, mem_rdata_d;
    logic [15:0]   div_q, div_d;
    logic          irq_q;

    tx_state_e     state_q, state_d;
    logic [15:0]   baud_q, baud_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shreg_q, shreg_d;
    logic          par_q, par_d;
    logic          busy;

    logic unused_bits;
    assign unused_bits = ^{mem_addr[31:4], mem_addr[1:0], mem_wdata[31:16]};

    // ---------------- bus side ----------------
    assign reg_addr      = mem_addr[3:2];
    assign is_write      = |mem_wstrb;
    // The cycle showing mem_ready belongs to the finished access
    assign req           = mem_valid && !mem_ready_q;
    assign data_push_req = req && is_write && (reg_addr == ADDR_DATA) && mem_wstrb[0];
    // A full FIFO still accepts when the serializer pops in the same cycle
    assign stall         = data_push_req && fifo_full && !fifo_pop;
    assign accept        = req && !stall;
    assign fifo_push     = data_push_req && !stall;
    assign busy          = (state_q != StIdle);

    always_comb begin
        status                    = '0;
        status[STAT_FULL]         = fifo_full;
        status[STAT_EMPTY]        = fifo_empty;
        status[STAT_BUSY]         = busy;
`ifdef UART_PARITY_EN
        status[STAT_PAR]          = 1'b1;
`endif
        status[STAT_LEVEL +: 8]   = 8'(fifo_level);
    end

    always_comb begin
        mem_ready_d = accept;
        mem_rdata_d = '0;
        div_d       = div_q;
        if (accept && !is_write) begin
            case (reg_addr)
                ADDR_STAT: mem_rdata_d = status;
                ADDR_DIV:  mem_rdata_d = {16'h0000, div_q};
                default:   mem_rdata_d = '0;
            endcase
        end
        if (accept && is_write && (reg_addr == ADDR_DIV)) begin
            if (mem_wstrb[0]) div_d[7:0]  = mem_wdata[7:0];
            if (mem_wstrb[1]) div_d[15:8] = mem_wdata[15:8];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mem_ready_q <= 1'b0;
            mem_rdata_q <= '0;
            div_q       <= DEFAULT_DIV;
            irq_q       <= 1'b1;
        end else begin
            mem_ready_q <= mem_ready_d;
            mem_rdata_q <= mem_rdata_d;
            div_q       <= div_d;
            irq_q       <= fifo_empty && !busy;
        end
    end

    assign mem_ready = mem_ready_q;
    assign mem_rdata = mem_rdata_q;
    assign irq_txe   = irq_q;

    sync_fifo #(
        .Width (8),
        .Depth (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (fifo_push),
        .wdata (mem_wdata[7:0]),
        .pop   (fifo_pop),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (fifo_level)
    );

    // ---------------- serializer ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            baud_q  <= '0;
            bit_q   <= '0;
            shreg_q <= '0;
            par_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shreg_q <= shreg_d;
            par_q   <= par_d;
        end
    end

    // baud_q counts the current bit down to 0; reloading from div_q at each
    // boundary is what makes a DIV write take effect on the next bit.
    always_comb begin
        state_d  = state_q;
        baud_d   = baud_q;
        bit_d    = bit_q;
        shreg_d  = shreg_q;
        par_d    = par_q;
        fifo_pop = 1'b0;
        case (state_q)
            StIdle: begin
                if (!fifo_empty) begin
                    state_d  = StStart;
                    fifo_pop = 1'b1;
                    shreg_d  = fifo_rdata;
                    par_d    = ^fifo_rdata;
                    baud_d   = div_q;
                    bit_d    = '0;
                end
            end
            StStart, StData, StParity, StStop: begin
                if (baud_q != 16'd0) begin
                    baud_d = baud_q - 16'd1;
                end else begin
                    baud_d = div_q;
                    case (state_q)
                        StStart: state_d = StData;
                        StData: begin
                            shreg_d = shreg_q >> 1;
                            bit_d   = bit_q + 3'd1;
                            if (bit_q == 3'd7) begin
`ifdef UART_PARITY_EN
                                state_d = StParity;
`else
                                state_d = StStop;
`endif
                            end
                        end
                        StParity: state_d = StStop;
                        default: begin
                            // End of stop bit: chain straight into the next frame
                            if (!fifo_empty) begin
                                state_d  = StStart;
                                fifo_pop = 1'b1;
                                shreg_d  = fifo_rdata;
                                par_d    = ^fifo_rdata;
                                bit_d    = '0;
                            end else begin
                                state_d = StIdle;
                            end
                        end
                    endcase
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        case (state_q)
            StStart:  uart_tx = 1'b0;
            StData:   uart_tx = shreg_q[0];
            StParity: uart_tx = par_q;
            default:  uart_tx = 1'b1;
        endcase
    end

endmodule

// File: tb/tb_uart_txm.sv
// Scoreboard bench for uart_txm: bus writes push expected bytes into a queue;
// a line monitor decodes each frame on uart_tx and compares every sample
// with the frame the byte should produce.
module tb_uart_txm;

    localparam int unsigned DEPTH = 4;
`ifdef UART_PARITY_EN
    localparam int NB = 11;
    localparam logic [31:0] PAR_FLAG = 32'h8;
`else
    localparam int NB = 10;
    localparam logic [31:0] PAR_FLAG = 32'h0;
`endif
    localparam logic [1:0] A_DATA = 2'd0, A_STAT = 2'd1, A_DIV = 2'd2, A_RSV = 2'd3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        mem_valid = 1'b0;
    logic        mem_ready;
    logic [31:0] mem_addr = '0;
    logic [31:0] mem_wdata = '0;
    logic [3:0]  mem_wstrb = '0;
    logic [31:0] mem_rdata;
    logic        uart_tx, irq_txe;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int cur_div = 433;
    logic mon_busy = 1'b0;
    logic [7:0] exp_q[$];
    int starts_q[$];

    uart_txm #(
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .mem_valid (mem_valid),
        .mem_ready (mem_ready),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_wstrb (mem_wstrb),
        .mem_rdata (mem_rdata),
        .uart_tx   (uart_tx),
        .irq_txe   (irq_txe)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    // Line level of frame bit idx for byte b: start, 8 data LSB first, [parity], stop
    function automatic logic model_bit(input logic [7:0] b, input int idx);
        if (idx == 0) return 1'b0;
        if (idx <= 8) return b[idx-1];
        if (NB == 11 && idx == 9) return ^b;
        return 1'b1;
    endfunction

    // Monitor: every sample of a frame must match the model, DIV+1 samples per bit
    initial begin : monitor
        logic [7:0] b;
        int bad;
        logic aborted;
        forever begin
            @(negedge clk);
            if (!rst && uart_tx === 1'b0) begin
                mon_busy = 1'b1;
                starts_q.push_back(cyc);
                aborted = 1'b0;
                bad = -1;
                if (exp_q.size() == 0) begin
                    check("unexpected_frame", 32'd1, 32'd0);
                    b = 8'h00;
                end else begin
                    b = exp_q.pop_front();
                end
                for (int k = 0; k < NB * (cur_div + 1); k++) begin
                    if (k > 0) @(negedge clk);
                    if (rst) begin
                        aborted = 1'b1;
                        break;
                    end
                    if (bad < 0 && uart_tx !== model_bit(b, k / (cur_div + 1))) bad = k;
                end
                // Reported value is the first mismatching sample index
                if (!aborted) check($sformatf("frame_%02h_div%0d", b, cur_div), bad, 32'hFFFF_FFFF);
                mon_busy = 1'b0;
            end
        end
    end

    task automatic bus(input logic [1:0] a, input logic [31:0] d, input logic [3:0] s,
                       output logic [31:0] rd, output int waited);
        mem_valid = 1'b1;
        mem_addr  = 32'h4000_0000 | {28'h0, a, 2'b00};
        mem_wdata = d;
        mem_wstrb = s;
        waited    = 0;
        rd        = '0;
        while (1) begin
            @(posedge clk);
            #1;
            waited++;
            if (mem_ready) begin
                rd = mem_rdata;
                break;
            end
            if (waited >= 3000) begin
                check("bus_timeout", waited, 0);
                break;
            end
        end
        mem_valid = 1'b0;
        mem_wstrb = '0;
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d, input logic [3:0] s,
                      output int waited);
        logic [31:0] rd;
        bus(a, d, s, rd, waited);
    endtask

    task automatic rdreg(input logic [1:0] a, output logic [31:0] rd);
        int w;
        bus(a, 32'h0, 4'h0, rd, w);
    endtask

    task automatic push_byte(input logic [7:0] b, output int waited);
        exp_q.push_back(b);
        wr(A_DATA, {24'h0, b}, 4'hF, waited);
    endtask

    task automatic set_div(input int d);
        int w;
        wr(A_DIV, d, 4'hF, w);
        cur_div = d;
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while (!(exp_q.size() == 0 && !mon_busy && irq_txe === 1'b1) && n < 20000) begin
            @(posedge clk);
            #1;
            n++;
        end
        check({name, "_idle_timeout"}, (n >= 20000), 0);
    endtask

    initial begin : stim
        logic [31:0] rd;
        int w;
        int lows;
        int diff;
        int nb;

        // Reset
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check("rst_uart_tx", uart_tx, 1);
        check("rst_irq_txe", irq_txe, 1);
        check("rst_mem_ready", mem_ready, 0);
        rdreg(A_STAT, rd);  check("rst_status", rd, 32'h2 | PAR_FLAG);
        rdreg(A_DIV, rd);   check("rst_div", rd, 433);
        rdreg(A_DATA, rd);  check("data_reads_zero", rd, 0);
        rdreg(A_RSV, rd);   check("rsv_reads_zero", rd, 0);

        // DIV=3, 0x55
        set_div(3);
        rdreg(A_DIV, rd);   check("div_readback", rd, 3);
        push_byte(8'h55, w);
        wait_idle("frame55");
        check("irq_after_frame", irq_txe, 1);

        // DIV=0, back-to-back frames with no idle gap
        set_div(0);
        starts_q.delete();
        push_byte(8'hA5, w);
        push_byte(8'h3C, w);
        wait_idle("b2b");
        check("b2b_frames", starts_q.size(), 2);
        diff = (starts_q.size() >= 2) ? starts_q[1] - starts_q[0] : -1;
        check("b2b_gap", diff, NB);

        // Byte strobes on DIV; DATA write without wstrb[0] pushes nothing
        wr(A_DIV, 32'h1234_5678, 4'b0010, w);
        rdreg(A_DIV, rd);   check("div_strobe", rd, 32'h5600);
        set_div(0);
        wr(A_RSV, 32'hFFFF_FFFF, 4'hF, w);
        wr(A_DATA, 32'hFF, 4'b0010, w);
        rdreg(A_STAT, rd);  check("no_push_status", rd, 32'h2 | PAR_FLAG);
        rdreg(A_DIV, rd);   check("rsv_write_ignored", rd, 0);

        // FIFO fill and stall, DIV=9
        set_div(9);
        for (int i = 0; i < 5; i++) begin
            push_byte(8'h10 + 8'(i), w);
            check($sformatf("no_stall_%0d", i + 1), (w <= 2), 1);
        end
        rdreg(A_STAT, rd);  check("full_status", rd, 32'h405 | PAR_FLAG);
        push_byte(8'h99, w);
        check("sixth_write_stalled", (w > 20), 1);
        wait_idle("fill");
        rdreg(A_STAT, rd);  check("drained_status", rd, 32'h2 | PAR_FLAG);

        // Parity-relevant directed frame
        set_div(1);
        push_byte(8'h07, w);
        wait_idle("p07");

        // Randomized bytes and divisors
        for (int it = 0; it < 8; it++) begin
            set_div(int'($urandom_range(0, 4)));
            rdreg(A_DIV, rd);
            check($sformatf("rand_div_%0d", it), rd, cur_div);
            nb = int'($urandom_range(1, 3));
            for (int j = 0; j < nb; j++) push_byte(8'($urandom), w);
            wait_idle($sformatf("rand_%0d", it));
        end

        // Reset during data bit 3 of a 0x00 frame
        set_div(3);
        push_byte(8'h00, w);
        repeat (18) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("midrst_uart_tx", uart_tx, 1);
        rst = 1'b0;
        cur_div = 433;
        exp_q.delete();
        rdreg(A_STAT, rd);  check("midrst_status", rd, 32'h2 | PAR_FLAG);
        rdreg(A_DIV, rd);   check("midrst_div", rd, 433);
        lows = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (uart_tx !== 1'b1) lows++;
        end
        check("midrst_line_quiet", lows, 0);
        check("midrst_irq", irq_txe, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
